conv1_param_loader: RTL and testbench

Configuration controller for the conv1 layer of the CNN. It receives conv1 filter weights and biases as a serial stream of 9-bit signed words over a valid/ready handshake and assembles them in a shadow buffer. It then commits the complete set atomically onto the packed weights/bias buses that feed the CNN core. The commit happens only while the core is not busy, so the core never sees a partially loaded parameter set.

---
 rtl/conv1_param_loader.sv | 186 ++++++++++++++++++
 tb/tb_conv1_param_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_param_loader.sv
// -----------------------------------------------------------------------------
// conv1_param_loader
//
// Loads the conv1 filter weights and biases from a serial stream of signed
// DW-bit words into a shadow buffer, then commits the complete set onto the
// packed weights/bias buses in a single cycle while the CNN core is idle.
// The core therefore never observes a partially loaded parameter set.
//
// Ports:
//   clk           system clock, rising edge
//   rstn          synchronous active-low reset
//   load_start    single-cycle request to begin a new load (IDLE only)
//   load_abort    cancel the load in progress (ignored in IDLE)
//   in_data       weight or bias word, two's complement
//   in_valid      in_data valid
//   in_ready      loader accepts a word this cycle (LOAD_W / LOAD_B)
//   cnn_busy      core computing; blocks the commit while high
//   weights       committed packed weights, word 0 in the MSBs
//   bias          committed packed biases, bias 0 in the MSBs
//   params_valid  at least one complete set has been committed
//   load_done     one-cycle pulse on the cycle after a commit
//   loading       loader is not idle
// -----------------------------------------------------------------------------
module conv1_param_loader #(
    parameter int N_FILT = 6,
    parameter int K_SIZE = 5,
    parameter int DW     = 9
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            load_start,
    input  logic                            load_abort,
    input  logic [DW-1:0]                   in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            cnn_busy,
    output logic [N_FILT*K_SIZE*K_SIZE*DW-1:0] weights,
    output logic [N_FILT*DW-1:0]            bias,
    output logic                            params_valid,
    output logic                            load_done,
    output logic                            loading
);

    localparam int W_WORDS = N_FILT * K_SIZE * K_SIZE;
    localparam int W_BITS  = W_WORDS * DW;
    localparam int B_BITS  = N_FILT * DW;

    localparam logic [7:0] LAST_W = 8'(W_WORDS - 1);
    localparam logic [7:0] LAST_B = 8'(N_FILT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_W      = 2'd1,
        LOAD_B      = 2'd2,
        WAIT_COMMIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [W_BITS-1:0]   shw_q, shw_d;
    logic [B_BITS-1:0]   shb_q, shb_d;
    logic [W_BITS-1:0]   weights_q, weights_d;
    logic [B_BITS-1:0]   bias_q, bias_d;
    logic                params_valid_q, params_valid_d;
    logic                load_done_q, load_done_d;
    logic                in_ready_s;
    logic                accept_s;

    // Ready is a pure decode of the state register; an abort on the same
    // edge still blocks the word, so the handshake qualifies with it.
    always_comb begin
        in_ready_s = (state_q == LOAD_W) || (state_q == LOAD_B);
        accept_s   = in_valid && in_ready_s && !load_abort;
    end

    // Next-state, counter, shadow shift and commit logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shw_d          = shw_q;
        shb_d          = shb_q;
        weights_d      = weights_q;
        bias_d         = bias_q;
        params_valid_d = params_valid_q;
        load_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Start wins over a simultaneous abort; abort is a no-op here.
                if (load_start) begin
                    state_d = LOAD_W;
                    cnt_d   = 8'd0;
                    shw_d   = {W_BITS{1'b0}};
                    shb_d   = {B_BITS{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD_W: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (accept_s) begin
                    // Shifting in at the LSB end leaves word 0 in the MSBs
                    // once all words have arrived.
                    shw_d = {shw_q[W_BITS-DW-1:0], in_data};
                    if (cnt_q == LAST_W) begin
                        state_d = LOAD_B;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = LOAD_W;
                end
            end

            LOAD_B: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (accept_s) begin
                    shb_d = {shb_q[B_BITS-DW-1:0], in_data};
                    if (cnt_q == LAST_B) begin
                        state_d = WAIT_COMMIT;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = LOAD_B;
                end
            end

            WAIT_COMMIT: begin
                // Abort beats the commit even when the core is idle.
                if (load_abort) begin
                    state_d = IDLE;
                end else if (!cnn_busy) begin
                    weights_d      = shw_q;
                    bias_d         = shb_q;
                    params_valid_d = 1'b1;
                    load_done_d    = 1'b1;
                    state_d        = IDLE;
                end else begin
                    state_d = WAIT_COMMIT;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            shw_q          <= {W_BITS{1'b0}};
            shb_q          <= {B_BITS{1'b0}};
            weights_q      <= {W_BITS{1'b0}};
            bias_q         <= {B_BITS{1'b0}};
            params_valid_q <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shw_q          <= shw_d;
            shb_q          <= shb_d;
            weights_q      <= weights_d;
            bias_q         <= bias_d;
            params_valid_q <= params_valid_d;
            load_done_q    <= load_done_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign loading      = (state_q != IDLE);
    assign weights      = weights_q;
    assign bias         = bias_q;
    assign params_valid = params_valid_q;
    assign load_done    = load_done_q;

endmodule

// File: tb/tb_conv1_param_loader.sv
// -----------------------------------------------------------------------------
// Testbench for conv1_param_loader. A table of load scenarios (pattern, valid
// duty, busy hold, abort point) with hand-computed expected boundary words is
// applied in a loop; every load that should commit pushes its full expected
// parameter set to a scoreboard queue, popped by a monitor on load_done.
// Hand-written sequences cover reset, start+abort in IDLE and reset mid-load.
// -----------------------------------------------------------------------------
module tb_conv1_param_loader;

    localparam int NW = 150;
    localparam int NB = 6;
    localparam int NT = NW + NB;

    logic          clk;
    logic          rstn;
    logic          load_start;
    logic          load_abort;
    logic [8:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cnn_busy;
    logic [1349:0] weights;
    logic [53:0]   bias;
    logic          params_valid;
    logic          load_done;
    logic          loading;

    conv1_param_loader dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .load_abort   (load_abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cnn_busy     (cnn_busy),
        .weights      (weights),
        .bias         (bias),
        .params_valid (params_valid),
        .load_done    (load_done),
        .loading      (loading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] wbase;     // weight word n = wbase + n
        logic [8:0] bbase;     // bias word b   = bbase - b
        int         duty;      // percent of cycles with in_valid
        int         busy;      // cycles cnn_busy held after the last bias
        int         abort_at;  // -1 none, 0..155 after that many words, 999 in WAIT_COMMIT
        logic [8:0] w0;        // expected weights[1349:1341] after the scenario
        logic [8:0] wlast;     // expected weights[8:0]
        logic [8:0] b0;        // expected bias[53:45]
        logic [8:0] blast;     // expected bias[8:0]
        bit         commit;
    } vec_t;

    typedef struct packed {
        logic [1349:0] w;
        logic [53:0]   b;
    } exp_t;

    vec_t          tbl [6];
    exp_t          sb_q [$];
    logic [1403:0] cur_set;   // model of the committed buses
    logic          cur_pv;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Compares {weights,bias} word by word and reports the first bad word.
    task automatic chk_bus(input string nm, input logic [1403:0] act, input logic [1403:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int i = 0; i < NT; i++) begin
                if (act[1403-9*i -: 9] !== exp[1403-9*i -: 9]) begin
                    k = i;
                    break;
                end
            end
            $display("FAIL %s word %0d got %h want %h", nm, k, act[1403-9*k -: 9], exp[1403-9*k -: 9]);
        end
    endtask

    // Scoreboard: each load_done pulse must match the oldest pending set.
    always @(negedge clk) begin
        if (rstn && load_done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_commit got 1 want 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_bus("sb_commit", {weights, bias}, {e.w, e.b});
                chk("sb_params_valid", 64'(params_valid), 64'd1);
            end
        end
    end

    task automatic run_load(input vec_t r);
        logic [8:0]    words [NT];
        logic [1403:0] pk;
        logic          rdy;
        int            idx, cyc, ready_cnt;
        bit            aborted;
        for (int n = 0; n < NW; n++) words[n] = r.wbase + 9'(n);
        for (int b = 0; b < NB; b++) words[NW+b] = r.bbase - 9'(b);
        for (int n = 0; n < NT; n++) pk[1403-9*n -: 9] = words[n];

        cnn_busy   = (r.busy > 0);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("loading_after_start", 64'(loading), 64'd1);

        idx = 0; cyc = 0; ready_cnt = 0; aborted = 0;
        while (idx < NT && cyc < 2000) begin
            if (r.abort_at >= 0 && r.abort_at < NT && idx == r.abort_at) begin
                load_abort = 1'b1;
                in_valid   = 1'b1;
                in_data    = words[idx];
                @(negedge clk);
                load_abort = 1'b0;
                in_valid   = 1'b0;
                chk("loading_after_abort", 64'(loading), 64'd0);
                aborted = 1;
                break;
            end
            in_valid = (r.duty >= 100) || ($urandom_range(0, 99) < r.duty);
            in_data  = words[idx];
            rdy      = in_ready;
            if (rdy) ready_cnt++;
            @(posedge clk);
            if (in_valid && rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 2000) chk("load_timeout", 64'(idx), 64'(NT));

        if (!aborted) begin
            if (r.duty >= 100) chk("in_ready_cycles", 64'(ready_cnt), 64'd156);
            if (r.abort_at < 0) sb_q.push_back(pk);
            for (int i = 0; i < r.busy; i++) begin
                chk("busy_in_ready", 64'(in_ready), 64'd0);
                chk("busy_load_done", 64'(load_done), 64'd0);
                chk_bus("busy_hold", {weights, bias}, cur_set);
                @(negedge clk);
            end
            cnn_busy = 1'b0;
            if (r.abort_at == 999) begin
                load_abort = 1'b1;
                @(negedge clk);
                load_abort = 1'b0;
                chk("wait_abort_loading", 64'(loading), 64'd0);
                chk("wait_abort_no_done", 64'(load_done), 64'd0);
            end else begin
                @(negedge clk);
                chk("commit_latency_done", 64'(load_done), 64'd1);
                @(negedge clk);
                chk("done_single_pulse", 64'(load_done), 64'd0);
                chk("sb_drained", 64'(sb_q.size()), 64'd0);
                cur_set = pk;
                cur_pv  = 1'b1;
            end
        end
        chk_bus("model_buses", {weights, bias}, cur_set);
        chk("params_valid", 64'(params_valid), 64'(cur_pv));
        chk("tbl_w0", 64'(weights[1349 -: 9]), 64'(r.w0));
        chk("tbl_wlast", 64'(weights[8:0]), 64'(r.wlast));
        chk("tbl_b0", 64'(bias[53 -: 9]), 64'(r.b0));
        chk("tbl_blast", 64'(bias[8:0]), 64'(r.blast));
        chk("tbl_idle", 64'(loading), 64'd0);
    endtask

    initial begin
        //          wbase    bbase    duty busy abort  w0       wlast    b0       blast    commit
        tbl[0] = '{9'h000, 9'h1FF, 100, 0,  -1,  9'h000, 9'h095, 9'h1FF, 9'h1FA, 1'b1};
        tbl[1] = '{9'h000, 9'h1FF, 50,  0,  -1,  9'h000, 9'h095, 9'h1FF, 9'h1FA, 1'b1};
        tbl[2] = '{9'h064, 9'h010, 100, 20, -1,  9'h064, 9'h0F9, 9'h010, 9'h00B, 1'b1};
        tbl[3] = '{9'h1F0, 9'h0AA, 100, 0,  70,  9'h064, 9'h0F9, 9'h010, 9'h00B, 1'b0};
        tbl[4] = '{9'h1F0, 9'h0AA, 100, 0,  -1,  9'h1F0, 9'h085, 9'h0AA, 9'h0A5, 1'b1};
        tbl[5] = '{9'h000, 9'h000, 100, 0,  999, 9'h1F0, 9'h085, 9'h0AA, 9'h0A5, 1'b0};

        rstn = 1'b0; load_start = 1'b0; load_abort = 1'b0;
        in_data = 9'h000; in_valid = 1'b0; cnn_busy = 1'b0;
        cur_set = '0; cur_pv = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk_bus("rst_buses", {weights, bias}, '0);
        chk("rst_params_valid", 64'(params_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_loading", 64'(loading), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);

        for (int t = 0; t < 6; t++) run_load(tbl[t]);

        // Start and abort together in IDLE: start wins, then abort returns.
        load_start = 1'b1; load_abort = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_beats_abort", 64'(loading), 64'd1);
        @(negedge clk);
        load_abort = 1'b0;
        chk("abort_to_idle", 64'(loading), 64'd0);
        chk_bus("abort_keeps_set", {weights, bias}, cur_set);

        // Reset in the middle of LOAD_B after a prior commit.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < NW + 2; i++) begin
            in_data = 9'(i);
            @(negedge clk);
        end
        chk("midb_loading", 64'(loading), 64'd1);
        chk("midb_in_ready", 64'(in_ready), 64'd1);
        chk("midb_pv", 64'(params_valid), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; in_valid = 1'b0;
        chk_bus("midrst_buses", {weights, bias}, '0);
        chk("midrst_params_valid", 64'(params_valid), 64'd0);
        chk("midrst_loading", 64'(loading), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_load_done", 64'(load_done), 64'd0);
        @(negedge clk);
        chk("midrst_no_commit", 64'(load_done), 64'd0);
        chk("sb_final_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
